// File: rtl/rho_rotate_pkg.sv
// rtl/rho_rotate_pkg.sv - shared constants, rho offset table and FSM encoding
package rho_rotate_pkg;

    localparam int WIDTH = 25;
    localparam int DEPTH = 64;
    localparam int CNT_W = 6;

    // Indexed by i = 5*y + x
    localparam int unsigned RHO_OFFSET [WIDTH] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rho_rotate_if.sv
// rtl/rho_rotate_if.sv - slice-serial handshake between rho stage and its neighbours
interface rho_rotate_if;
    import rho_rotate_pkg::*;

    logic             start;
    logic [WIDTH-1:0] in;
    logic             read;
    logic [WIDTH-1:0] out;
    logic             ready;
    logic             total_ready;
    logic             busy;

    modport master (
        output start, in,
        input  read, out, ready, total_ready, busy
    );

    modport slave (
        input  start, in,
        output read, out, ready, total_ready, busy
    );

endinterface

// File: rtl/rho_rotate_lane.sv
// rtl/rho_rotate_lane.sv - one 64-bit lane, written by slice index, read back rotated by R
module rho_rotate_lane
    import rho_rotate_pkg::*;
#(
    parameter int unsigned R = 0
) (
    input  logic             clk,
    input  logic             we,
    input  logic [CNT_W-1:0] cnt,
    input  logic             d,
    output logic             q
);

    localparam logic [CNT_W-1:0] R_W = CNT_W'(R);

    // Lane contents are fully rewritten each LOAD, so no reset is needed
    logic [DEPTH-1:0] lane;

    always_ff @(posedge clk) begin
        if (we) begin
            lane[cnt] <= d;
        end
    end

    // Modular subtraction wraps naturally at CNT_W bits
    assign q = lane[cnt - R_W];

endmodule

// File: rtl/rho_rotate.sv
// rtl/rho_rotate.sv - buffers one Keccak state slice-serially and replays it lane-rotated
module rho_rotate
    import rho_rotate_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    rho_rotate_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rot;
    logic             lane_we;

    assign lane_we = (state == LOAD);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        rho_rotate_lane #(
            .R (RHO_OFFSET[i])
        ) u_lane (
            .clk (clk),
            .we  (lane_we),
            .cnt (cnt),
            .d   (bus.in[i]),
            .q   (rot[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.read        <= 1'b0;
            bus.out         <= '0;
            bus.ready       <= 1'b0;
            bus.total_ready <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.ready       <= 1'b0;
            bus.total_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        bus.read <= 1'b1;
                        bus.busy <= 1'b1;
                    end
                end
                LOAD: begin
                    // cnt wraps to 0 after the last slice, ready for EMIT
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= EMIT;
                        bus.read <= 1'b0;
                    end
                end
                EMIT: begin
                    bus.out   <= rot;
                    bus.ready <= 1'b1;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.total_ready <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rho_rotate.sv
// tb/tb_rho_rotate.sv - self-checking bench for rho_rotate
module tb_rho_rotate;

    localparam int MAXR = 20;

    logic clk = 1'b0;
    logic rst;

    rho_rotate_if bus ();

    rho_rotate dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int rho_tab [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                         41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    logic [24:0] stim [MAXR*64];
    logic [24:0] got  [MAXR*64];

    int cyc = 0;
    int rd_n, rdy_n, tr_n, last_rdy_cyc, first_rd_cyc, first_rdy_cyc;
    int tr_gap [$];
    int tr_rdy [$];
    int tr_cyc [$];
    int total = 0;
    int bad = 0;

    typedef struct {
        int          zi;
        logic [24:0] vi;
        int          zo0;
        logic [24:0] vo0;
        int          zo1;
        logic [24:0] vo1;
    } vec_t;

    vec_t vecs [5];

    // Feed slices on request and capture emitted slices, all away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (bus.read) begin
            if (rd_n == 0) first_rd_cyc = cyc;
            bus.in = (rd_n < MAXR*64) ? stim[rd_n] : 25'($urandom);
            rd_n++;
        end else begin
            bus.in = 25'($urandom);
        end
        if (bus.ready) begin
            if (rdy_n == 0) first_rdy_cyc = cyc;
            if (rdy_n < MAXR*64) got[rdy_n] = bus.out;
            rdy_n++;
            last_rdy_cyc = cyc;
        end
        if (bus.total_ready) begin
            tr_n++;
            tr_gap.push_back(cyc - last_rdy_cyc);
            tr_rdy.push_back(rdy_n);
            tr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        rd_n = 0; rdy_n = 0; tr_n = 0;
        first_rd_cyc = -1; first_rdy_cyc = -1; last_rdy_cyc = -1000;
        tr_gap.delete(); tr_rdy.delete(); tr_cyc.delete();
    endtask

    function automatic logic [24:0] golden(input int run, input int z);
        logic [24:0] v;
        for (int i = 0; i < 25; i++) v[i] = stim[run*64 + ((z - rho_tab[i] + 64) % 64)][i];
        return v;
    endfunction

    task automatic run(input int nruns, input bit poke, output int sc);
        int k;
        clear();
        step();
        bus.start = 1'b1;
        sc = cyc;
        k = 0;
        while (tr_n < nruns && k < 200*nruns) begin
            step();
            k++;
            bus.start = (rd_n <= 64*(nruns-1)) ||
                        (poke && (cyc == sc+10 || cyc == sc+80 || cyc == sc+129));
        end
        bus.start = 1'b0;
        check("run_timeout", 32'(tr_n >= nruns), 32'd1);
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic check_protocol(input int nruns, input string tag);
        check({tag, "_reads"}, rd_n, 64*nruns);
        check({tag, "_readies"}, rdy_n, 64*nruns);
        check({tag, "_total_ready"}, tr_n, nruns);
        for (int k = 0; k < tr_gap.size(); k++) begin
            check($sformatf("%s_tr_gap%0d", tag, k), tr_gap[k], 1);
            check($sformatf("%s_tr_rdy%0d", tag, k), tr_rdy[k], 64*(k+1));
        end
        check({tag, "_out_hold"}, bus.out, got[64*nruns-1]);
        check({tag, "_idle_busy"}, bus.busy, 1'b0);
    endtask

    task automatic check_model(input int nruns, input string tag);
        for (int r = 0; r < nruns; r++)
            for (int z = 0; z < 64; z++)
                check($sformatf("%s_r%0d_z%0d", tag, r, z), got[r*64+z], golden(r, z));
    endtask

    initial begin
        int sc;
        logic [24:0] exp;
        bus.start = 1'b0;
        rst = 1'b0;

        // Reset with random stimulus on start
        for (int i = 0; i < 3; i++) begin
            bus.start = 1'($urandom);
            step();
            check("rst_read", bus.read, 1'b0);
            check("rst_ready", bus.ready, 1'b0);
            check("rst_total_ready", bus.total_ready, 1'b0);
            check("rst_busy", bus.busy, 1'b0);
            check("rst_out", bus.out, 25'h0);
        end
        bus.start = 1'b0;
        rst = 1'b1;
        clear();
        for (int i = 0; i < 10; i++) step();
        check("idle_reads", rd_n, 0);
        check("idle_readies", rdy_n, 0);
        check("idle_busy", bus.busy, 1'b0);

        // Directed single-state vectors
        vecs[0] = '{5,  25'h4,       3,  25'h4,       -1, 25'h0};
        vecs[1] = '{0,  25'h3,       0,  25'h1,        1, 25'h2};
        vecs[2] = '{60, 25'h1000000, 10, 25'h1000000, -1, 25'h0};
        vecs[3] = '{63, 25'h20,      35, 25'h20,      -1, 25'h0};
        vecs[4] = '{10, 25'h1080,    53, 25'h1000,    16, 25'h80};
        for (int v = 0; v < 5; v++) begin
            for (int z = 0; z < 64; z++) stim[z] = 25'h0;
            stim[vecs[v].zi] = vecs[v].vi;
            run(1, 1'b0, sc);
            if (v == 0) begin
                check("lat_first_read", first_rd_cyc, sc+1);
                check("lat_first_ready", first_rdy_cyc, sc+66);
                check("lat_total_ready", tr_cyc[0], sc+130);
            end
            check_protocol(1, $sformatf("vec%0d", v));
            for (int z = 0; z < 64; z++) begin
                exp = 25'h0;
                if (z == vecs[v].zo0) exp |= vecs[v].vo0;
                if (z == vecs[v].zo1) exp |= vecs[v].vo1;
                check($sformatf("vec%0d_z%0d", v, z), got[z], exp);
            end
        end

        // Random back-to-back states with start held high
        for (int i = 0; i < MAXR*64; i++) stim[i] = 25'($urandom);
        run(MAXR, 1'b0, sc);
        check_protocol(MAXR, "rand");
        check_model(MAXR, "rand");

        // start pulses during LOAD, EMIT and DONE must be ignored
        for (int i = 0; i < 64; i++) stim[i] = 25'($urandom);
        run(1, 1'b1, sc);
        check_protocol(1, "poke");
        check_model(1, "poke");

        // Reset in the middle of LOAD, then a fresh run
        for (int i = 0; i < 64; i++) stim[i] = 25'($urandom);
        clear();
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 100 && rd_n < 31; k++) step();
        check("mid_rst_reached", 32'(rd_n >= 31), 32'd1);
        rst = 1'b0;
        step();
        check("mid_rst_read", bus.read, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_out", bus.out, 25'h0);
        rst = 1'b1;
        for (int i = 0; i < 64; i++) stim[i] = 25'($urandom);
        run(1, 1'b0, sc);
        check_protocol(1, "after_rst");
        check_model(1, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rho_rotate.md
Name: rho_rotate

Overview:
- Lane-rotation (rho) stage of the slice-serial Keccak-f round datapath.
- Sits directly upstream of the permutation (pi) stage. It consumes the 64 slices of one state, 25 bits per slice, and produces 64 rotated slices on the same slice-serial handshake that the permutation stage expects.
- Each 64-bit lane (x,y) is rotated along z by the fixed Keccak rho offset. The whole state is buffered first, then replayed.

Parameters:
- WIDTH, 25, bits per slice (5x5 lanes).
- DEPTH, 64, slices per state (lane length).
- CNT_W, 6, slice counter width (log2 DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to process one state. Honoured only in IDLE.
- in  input  25  incoming slice. Sampled on every cycle where read=1.
- read  output  1  high while consuming in. Slice index = current counter.
- out  output  25  rotated slice, registered.
- ready  output  1  out holds a valid slice this cycle.
- total_ready  output  1  one-cycle pulse: full state emitted.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Bit mapping: bit i = 5*y + x. Lane (x,y) of slice z is in[5*y+x] of slice z.
- Rotation rule: out slice z, bit i = stored slice ((z - r_i) mod 64), bit i. This is a left rotate of the lane by r_i. All arithmetic is CNT_W-bit unsigned, so wrap-around is natural.
- Offsets r[x,y]:
  - y0: 0, 1, 62, 28, 27
  - y1: 36, 44, 6, 55, 20
  - y2: 3, 10, 43, 25, 39
  - y3: 41, 45, 15, 21, 8
  - y4: 18, 2, 61, 56, 14
  - (x = 0..4 left to right within each row.)
- Storage: 25 lane registers of 64 bits each, written by slice index. Storage is not cleared by reset.
- FSM states and transitions:
  - IDLE -> LOAD on start. Counter is set to 0.
  - LOAD: read=1 every cycle. in is written into bit position cnt of every lane; cnt increments. After cnt=63 is written, go to EMIT with cnt=0.
  - EMIT: each cycle the rotated slice for index cnt is registered into out and cnt increments. ready is high the following cycle, aligned with out. After cnt=63 is emitted, go to DONE.
  - DONE: total_ready=1 for exactly one cycle, which is the cycle after the last ready. Then go to IDLE.
- Timing:
  - Latency from start to first read: 1 cycle.
  - First ready: 66 cycles after start.
  - One full state takes 130 cycles (start to the total_ready cycle).
- Reset values: read=0, ready=0, total_ready=0, busy=0, out=0, cnt=0, state=IDLE.
- Boundary conditions:
  - start outside IDLE, including during DONE, is ignored; no queuing.
  - start held high across IDLE re-entry triggers a new run. Back-to-back runs are therefore legal, with 1 idle cycle between total_ready and the next read.
  - rst low in any state returns to IDLE on the next edge with all outputs at reset values. The partially loaded state is discarded.
  - out holds its last value when ready=0. Consumers must qualify out with ready.
  - in is don't-care when read=0.

Decomposition:
- Shared keccak package holds:
  - the WIDTH and DEPTH constants;
  - the 25-entry rho offset table, indexed by i = 5*y+x;
  - the FSM state encoding.
- Natural sub-module: rho_lane, a 64-bit lane register with write-enable at index cnt and a combinational read of bit (cnt - r) mod 64. It is instantiated 25 times with r as a parameter.
- The top-level rho_rotate holds the FSM, the counter and the output register.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random in/start -> all outputs 0, busy=0. Release, idle 10 cycles -> no read or ready.
- Single bit, wrap case: load slice 5 = 25'h4 (x=2,y=0, r=62), all other slices 0 -> exactly one ready cycle has out=25'h4, at slice index 3. All other slices are 0.
- Identity lane plus small offset: slice 0 = 25'h3 (bits 0 and 1) -> out slice 0 = 25'h1, out slice 1 = 25'h2, all other slices 0.
- Random state vs. reference model: 20 random 64x25 states, back-to-back, start held high. Check that out matches the golden rho for every slice, that there are exactly 64 ready pulses per run, and that total_ready is one cycle after the last ready.
- Protocol robustness: pulse start during LOAD, EMIT and DONE -> no restart, no extra reads, result unchanged.
- Reset mid-operation: assert rst at LOAD slice 30, then start a fresh run -> the output corresponds only to the new state, with exactly 64 reads.
